// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit
//   Data-memory initiator for the multicycle RISC-V datapath: b/h/w loads and
//   stores over a req/ready word port, with read-modify-write for sb/sh.
//   Revision: 1.0
// ============================================================================
module load_store_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       byte_addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              misalign,
  output logic [31:0]       load_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [31:0] r_store_data;

  logic        w_illegal;
  logic [31:0] w_merged;
  logic [31:0] w_load_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused;

  // Address bits above the memory window wrap silently.
  assign w_unused = &{1'b0, byte_addr[31:ADDR_W+2]};

  always_comb begin
    w_illegal = 1'b0;
    case (funct3)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = byte_addr[0];
      3'b010:  w_illegal = |byte_addr[1:0];
      3'b100:  w_illegal = is_store;
      3'b101:  w_illegal = is_store | byte_addr[0];
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_merged = mem_rdata;
    if (r_funct3[0]) begin
      if (r_lane[1]) w_merged[31:16] = r_store_data[15:0];
      else           w_merged[15:0]  = r_store_data[15:0];
    end else begin
      case (r_lane)
        2'd0:    w_merged[7:0]   = r_store_data[7:0];
        2'd1:    w_merged[15:8]  = r_store_data[7:0];
        2'd2:    w_merged[23:16] = r_store_data[7:0];
        default: w_merged[31:24] = r_store_data[7:0];
      endcase
    end
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_is_store   <= 1'b0;
      r_funct3     <= 3'd0;
      r_lane       <= 2'd0;
      r_store_data <= 32'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      misalign     <= 1'b0;
      load_data    <= 32'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_is_store   <= is_store;
            r_funct3     <= funct3;
            r_lane       <= byte_addr[1:0];
            r_store_data <= store_data;
            mem_addr     <= byte_addr[ADDR_W+1:2];
            busy         <= 1'b1;
            if (w_illegal) begin
              r_state  <= FIN;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else if (is_store && funct3 == 3'b010) begin
              r_state   <= WR;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= store_data;
            end else begin
              r_state <= RD;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end
          end
        end
        RD: begin
          if (mem_ready) begin
            if (r_is_store) begin
              // Request stays up; only the direction and data change.
              r_state   <= WR;
              mem_we    <= 1'b1;
              mem_wdata <= w_merged;
            end else begin
              r_state   <= FIN;
              mem_req   <= 1'b0;
              done      <= 1'b1;
              load_data <= w_load_ext;
            end
          end
        end
        WR: begin
          if (mem_ready) begin
            r_state <= FIN;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit
//   Vector table, hand sequences and randomized traffic against a memory model.
//   Revision: 1.0
// ============================================================================
module tb_load_store_unit;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              is_store = 1'b0;
  logic [2:0]        funct3 = 3'd0;
  logic [31:0]       byte_addr = 32'd0;
  logic [31:0]       store_data = 32'd0;
  logic              busy, done, misalign, mem_req, mem_we;
  logic [31:0]       load_data, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready = 1'b1;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  int  checks = 0, errors = 0;
  int  rd_hs = 0, wr_hs = 0, req_cyc = 0, waits = 0;
  bit  rand_ready = 1'b0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .byte_addr(byte_addr), .store_data(store_data), .busy(busy), .done(done),
    .misalign(misalign), .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (rst_n && mem_req) begin
      req_cyc++;
      if (!mem_ready) waits++;
      else if (mem_we) begin
        wr_hs++;
        mem[mem_addr] <= mem_wdata;
      end else rd_hs++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // A stalled request must hold every request signal until the handshake.
  logic              p_pend = 1'b0, p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [31:0]       p_wdata;
  always @(posedge clk) begin
    if (p_pend)
      chk("req_stable", {mem_req, mem_we, mem_addr, mem_wdata[15:0]},
          {1'b1, p_we, p_addr, p_wdata[15:0]});
    p_pend  = rst_n && mem_req && !mem_ready;
    p_we    = mem_we;
    p_addr  = mem_addr;
    p_wdata = mem_wdata;
  end

  always @(negedge clk)
    if (rand_ready) mem_ready = ($urandom_range(0, 2) != 0);

  task automatic run(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, output int cyc, output logic mis,
                     output logic [31:0] ld);
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; byte_addr = a; store_data = sd;
    rd_hs = 0; wr_hs = 0; req_cyc = 0; waits = 0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    mis = misalign;
    ld  = load_data;
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_one_pulse", {31'd0, done}, 32'd0);
  endtask

  // Reference: byte-level semantics of RISC-V loads/stores on a word memory.
  function automatic void ref_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd, inout logic [31:0] word,
                                 inout logic [31:0] ld, output bit mis, output int nacc);
    int size, shamt;
    logic [31:0] mask, v;
    mis  = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (st && f3[2]);
    nacc = 0;
    if (mis) return;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (int'(a[1:0]) % size != 0) begin
      mis = 1'b1;
      return;
    end
    shamt = 8 * int'(a[1:0]);
    mask  = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
    if (st) begin
      word = (word & ~(mask << shamt)) | ((sd & mask) << shamt);
      nacc = (size == 4) ? 1 : 2;
    end else begin
      v = (word >> shamt) & mask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      ld   = v;
      nacc = 1;
    end
  endfunction

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] init;
    logic [31:0] exp_ld;
    logic        exp_mis;
    logic [31:0] exp_word;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int          cyc;
    logic        mis;
    logic [31:0] ld;
    logic [4:0]  idx;

    vecs[0]  = '{0, 3'b010, 32'h0000000C, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2};
    vecs[1]  = '{0, 3'b000, 32'h0000000D, 32'h0, 32'h12348056, 32'hFFFFFF80, 0, 32'h12348056, 2};
    vecs[2]  = '{0, 3'b100, 32'h0000000D, 32'h0, 32'h12348056, 32'h00000080, 0, 32'h12348056, 2};
    vecs[3]  = '{0, 3'b001, 32'h0000000E, 32'h0, 32'h12348056, 32'h00001234, 0, 32'h12348056, 2};
    vecs[4]  = '{1, 3'b000, 32'h0000000E, 32'h000000AB, 32'h11223344, 32'h00001234, 0, 32'h11AB3344, 3};
    vecs[5]  = '{0, 3'b001, 32'h00000003, 32'h0, 32'h55667788, 32'h00001234, 1, 32'h55667788, 1};
    vecs[6]  = '{1, 3'b010, 32'h00000006, 32'hFFFFFFFF, 32'h01020304, 32'h00001234, 1, 32'h01020304, 1};
    vecs[7]  = '{1, 3'b001, 32'h0000000A, 32'h0000BEEF, 32'h11223344, 32'h00001234, 0, 32'hBEEF3344, 3};
    vecs[8]  = '{0, 3'b101, 32'h00000012, 32'h0, 32'h80017FFF, 32'h00008001, 0, 32'h80017FFF, 2};
    vecs[9]  = '{0, 3'b001, 32'h00000012, 32'h0, 32'h80017FFF, 32'hFFFF8001, 0, 32'h80017FFF, 2};
    vecs[10] = '{1, 3'b100, 32'h00000010, 32'h0, 32'h0BADF00D, 32'hFFFF8001, 1, 32'h0BADF00D, 1};
    vecs[11] = '{0, 3'b011, 32'h00000010, 32'h0, 32'h0BADF00D, 32'hFFFF8001, 1, 32'h0BADF00D, 1};
    vecs[12] = '{0, 3'b010, 32'hFFFFFF8C, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 32'hCAFEF00D, 2};
    vecs[13] = '{0, 3'b000, 32'h00000013, 32'h0, 32'h7F000000, 32'h0000007F, 0, 32'h7F000000, 2};
    vecs[14] = '{1, 3'b000, 32'h00000010, 32'hFFFFFF55, 32'hAAAAAAAA, 32'h0000007F, 0, 32'hAAAAAA55, 3};

    for (int i = 0; i < 32; i++) mem[i] = $urandom;

    repeat (2) @(negedge clk);
    chk("reset_outs", {28'd0, busy, done, misalign, mem_req}, 32'd0);
    chk("reset_we_addr", {26'd0, mem_we, mem_addr}, 32'd0);
    chk("reset_load_data", load_data, 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    // Zero-wait vector table.
    for (int i = 0; i < 15; i++) begin
      idx = vecs[i].addr[6:2];
      mem[idx] = vecs[i].init;
      run(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].sd, cyc, mis, ld);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
      chk($sformatf("v%0d_misalign", i), {31'd0, mis}, {31'd0, vecs[i].exp_mis});
      chk($sformatf("v%0d_load_data", i), ld, vecs[i].exp_ld);
      chk($sformatf("v%0d_mem_word", i), mem[idx], vecs[i].exp_word);
      chk($sformatf("v%0d_req_cycles", i), req_cyc, vecs[i].exp_cyc - 1);
    end

    // sw with a stalled memory; a start pulsed mid-wait must be ignored.
    mem[4] = 32'h0; mem[0] = 32'h13579BDF; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; byte_addr = 32'h10; store_data = 32'h5A5AC3C3;
    wr_hs = 0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("stall_req", {29'd0, mem_req, mem_we, busy}, 32'd7);
      chk("stall_addr", {27'd0, mem_addr}, 32'd4);
      chk("stall_wdata", mem_wdata, 32'h5A5AC3C3);
      chk("stall_no_done", {31'd0, done}, 32'd0);
      if (k == 3) begin
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; byte_addr = 32'h0;
      end
      if (k == 4) start = 1'b0;
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("stall_done", {30'd0, done, misalign}, 32'd2);
    chk("stall_mem4", mem[4], 32'h5A5AC3C3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ignored_start_idle", {30'd0, mem_req, done}, 32'd0);
    end
    chk("stall_one_write", wr_hs, 1);

    // Reset while the RMW read is pending abandons the request.
    mem[2] = 32'h77777777; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; funct3 = 3'b001; byte_addr = 32'h08; store_data = 32'h1234;
    wr_hs = 0;
    @(negedge clk);
    start = 1'b0;
    chk("rst_rd_req", {30'd0, mem_req, mem_we}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_abandon", {29'd0, mem_req, busy, done}, 32'd0);
    chk("rst_addr", {27'd0, mem_addr}, 32'd0);
    rst_n = 1'b1; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_no_write", wr_hs, 0);
    chk("rst_mem2", mem[2], 32'h77777777);
    run(1'b0, 3'b010, 32'h08, 32'h0, cyc, mis, ld);
    chk("post_rst_cycles", cyc, 2);
    chk("post_rst_ld", ld, 32'h77777777);

    // Randomized traffic with random wait states.
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      bit          st, emis;
      int          nacc;
      logic [2:0]  f3;
      logic [31:0] a, sd, eword, eld;
      st = $urandom_range(0, 1);
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
         : (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4)));
      if (!st && f3 == 3'd3) f3 = 3'd4;
      if (!st && f3 == 3'd4 && n[0]) f3 = 3'd5;
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'd2) ? 2'd0 : (f3[0] ? {a[1], 1'b0} : a[1:0]);
      sd = $urandom;
      idx   = a[6:2];
      eword = ref_mem[idx];
      eld   = load_data;
      ref_op(st, f3, a, sd, eword, eld, emis, nacc);
      run(st, f3, a, sd, cyc, mis, ld);
      ref_mem[idx] = eword;
      chk("rnd_cycles", cyc, 1 + nacc + waits);
      chk("rnd_misalign", {31'd0, mis}, {31'd0, emis});
      chk("rnd_load_data", ld, eld);
      chk("rnd_mem_word", mem[idx], eword);
      chk("rnd_accesses", rd_hs + wr_hs, nacc);
    end
    rand_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
